// File: rtl/rt8_errcomp_pkg.sv
// Shared definitions for the rt8 error-compensation consumer.
// Holds the column weights, the exact-count limit, the packed result record
// and the per-sample arithmetic so the top and any future users agree on it.
package rt8_errcomp_pkg;

  localparam int SUM_W       = 1;  // column weight of the compressor sum
  localparam int CARRY_W     = 2;  // column weight of carry / cout1 / cout2
  localparam int ERR_PENALTY = 2;  // column-weight loss per asserted stage flag
  localparam int MAX_EXACT   = 8;  // largest count eight one-bit inputs can make

  typedef struct packed {
    logic       inconsistent;
    logic [2:0] delta;
    logic [3:0] exact;
    logic [2:0] apx;
  } res_t;

  localparam int RES_W = $bits(res_t);

  // Reconstruct approximate/exact counts from one compressor sample.
  // Worst case is 7 + 6 = 13, so 4 bits never overflow.
  function automatic res_t calc_res(input logic s, input logic c,
                                    input logic c1, input logic c2,
                                    input logic [2:0] u);
    res_t       r;
    logic [3:0] a;
    logic [3:0] pc;
    logic [3:0] d;
    logic [3:0] e;
    a  = (s  ? 4'(SUM_W)   : 4'd0) + (c  ? 4'(CARRY_W) : 4'd0)
       + (c1 ? 4'(CARRY_W) : 4'd0) + (c2 ? 4'(CARRY_W) : 4'd0);
    pc = {3'b0, u[0]} + {3'b0, u[1]} + {3'b0, u[2]};
    d  = 4'(ERR_PENALTY) * pc;
    e  = a + d;
    r.apx          = a[2:0];
    r.delta        = d[2:0];
    r.exact        = e;
    r.inconsistent = (e > 4'(MAX_EXACT));
    return r;
  endfunction

endpackage

// File: rtl/rt8_errcomp_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with count-based full/empty.
// Ports: clk, rst_n (async low); push/pop requests (qualified internally by
// full/empty); wdata in; rdata = head entry; full, empty status.
// There is no push-through: full is derived from the registered count only,
// so a push is refused when full even if a pop happens in the same cycle.
module rt8_errcomp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr;
  logic [PW-1:0]               rd_ptr;
  logic [PW:0]                 count;
  logic                        do_push;
  logic                        do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rt8_errcomp.sv
// Consumer of the 8:2 approximate-compressor column outputs.
// Per accepted sample it rebuilds the approximate count, the compensation
// delta (2 per under-reporting 4:2 stage), the exact count and a flag for
// exact counts that eight real inputs cannot produce. Results queue in a
// small FIFO; saturating statistics track samples, error events and the
// accumulated error magnitude.
// Ports: clk, rst_n (async low); in_valid/in_ready + sample fields
// (sum_i, carry_i, cout1_i, cout2_i, u_err_i); out_valid/out_ready + result
// fields (apx_cnt, exact_cnt, delta, inconsistent); clr_stats and the three
// statistics counters.
module rt8_errcomp
  import rt8_errcomp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sum_i,
  input  logic             carry_i,
  input  logic             cout1_i,
  input  logic             cout2_i,
  input  logic [2:0]       u_err_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       apx_cnt,
  output logic [3:0]       exact_cnt,
  output logic [2:0]       delta,
  output logic             inconsistent,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_evt_cnt,
  output logic [CNT_W-1:0] err_mag_acc
);

  localparam int CW1 = CNT_W + 1;

  res_t res_in;
  res_t res_head;
  res_t res_out;
  logic full;
  logic empty;
  logic push;

  assign res_in    = calc_res(sum_i, carry_i, cout1_i, cout2_i, u_err_i);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push      = in_valid & in_ready;

  rt8_errcomp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (out_ready),
    .wdata (res_in),
    .rdata (res_head),
    .full  (full),
    .empty (empty)
  );

  // Storage is not reset, so mask the head to zero whenever nothing is held.
  assign res_out      = empty ? '0 : res_head;
  assign apx_cnt      = res_out.apx;
  assign exact_cnt    = res_out.exact;
  assign delta        = res_out.delta;
  assign inconsistent = res_out.inconsistent;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [2:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + CW1'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Clear wins over a same-cycle push; the sample still enters the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt  <= '0;
      err_evt_cnt <= '0;
      err_mag_acc <= '0;
    end else if (clr_stats) begin
      sample_cnt  <= '0;
      err_evt_cnt <= '0;
      err_mag_acc <= '0;
    end else if (push) begin
      sample_cnt  <= sat_add(sample_cnt, 3'd1);
      err_evt_cnt <= sat_add(err_evt_cnt, {2'b0, |u_err_i});
      err_mag_acc <= sat_add(err_mag_acc, res_in.delta);
    end
  end

endmodule

// File: tb/tb_rt8_errcomp.sv
module tb_rt8_errcomp;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             sum_i = 1'b0;
  logic             carry_i = 1'b0;
  logic             cout1_i = 1'b0;
  logic             cout2_i = 1'b0;
  logic [2:0]       u_err_i = 3'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       apx_cnt;
  logic [3:0]       exact_cnt;
  logic [2:0]       delta;
  logic             inconsistent;
  logic             clr_stats = 1'b0;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_evt_cnt;
  logic [CNT_W-1:0] err_mag_acc;

  always #5 clk = ~clk;

  rt8_errcomp #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum_i(sum_i), .carry_i(carry_i), .cout1_i(cout1_i), .cout2_i(cout2_i),
    .u_err_i(u_err_i), .out_valid(out_valid), .out_ready(out_ready),
    .apx_cnt(apx_cnt), .exact_cnt(exact_cnt), .delta(delta),
    .inconsistent(inconsistent), .clr_stats(clr_stats),
    .sample_cnt(sample_cnt), .err_evt_cnt(err_evt_cnt), .err_mag_acc(err_mag_acc)
  );

  typedef struct packed {
    logic       inc;
    logic [2:0] dl;
    logic [3:0] ex;
    logic [2:0] ap;
  } exp_t;

  typedef struct {
    logic       s, c, c1, c2;
    logic [2:0] u;
    exp_t       e;
  } vec_t;

  exp_t q[$];
  exp_t drv_exp = '0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   e_smp = 0, e_evt = 0, e_mag = 0;

  function automatic exp_t mk_exp(int ap, int ex, int dl, int inc);
    exp_t e;
    e.ap = 3'(ap); e.ex = 4'(ex); e.dl = 3'(dl); e.inc = (inc != 0);
    return e;
  endfunction

  function automatic vec_t mkv(logic s, logic c, logic c1, logic c2, logic [2:0] u,
                               int ap, int ex, int dl, int inc);
    vec_t v;
    v.s = s; v.c = c; v.c1 = c1; v.c2 = c2; v.u = u;
    v.e = mk_exp(ap, ex, dl, inc);
    return v;
  endfunction

  // Reference arithmetic in plain integers.
  function automatic exp_t ref_res(logic s, logic c, logic c1, logic c2, logic [2:0] u);
    int a, d;
    a = int'(s) + 2 * (int'(c) + int'(c1) + int'(c2));
    d = 2 * (int'(u[0]) + int'(u[1]) + int'(u[2]));
    return mk_exp(a, a + d, d, (a + d) > 8);
  endfunction

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: queue depth mirrors FIFO occupancy; head fields checked every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      e_smp = 0; e_evt = 0; e_mag = 0;
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() != DEPTH);
      chk("sample_cnt", sample_cnt, e_smp);
      chk("err_evt_cnt", err_evt_cnt, e_evt);
      chk("err_mag_acc", err_mag_acc, e_mag);
      if (q.size() != 0) begin
        chk("apx_cnt", apx_cnt, q[0].ap);
        chk("exact_cnt", exact_cnt, q[0].ex);
        chk("delta", delta, q[0].dl);
        chk("inconsistent", inconsistent, q[0].inc);
      end else begin
        chk("idle_out", {inconsistent, delta, exact_cnt, apx_cnt}, 0);
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (in_valid && in_ready) q.push_back(drv_exp);
      if (clr_stats) begin
        e_smp = 0; e_evt = 0; e_mag = 0;
      end else if (in_valid && in_ready) begin
        e_smp = sat(e_smp + 1);
        e_evt = sat(e_evt + int'(|u_err_i));
        e_mag = sat(e_mag + int'(drv_exp.dl));
      end
    end
  end

  task automatic set_in(input logic s, input logic c, input logic c1, input logic c2,
                        input logic [2:0] u, input exp_t e);
    sum_i = s; carry_i = c; cout1_i = c1; cout2_i = c2; u_err_i = u; drv_exp = e;
  endtask

  task automatic push_s(input logic s, input logic c, input logic c1, input logic c2,
                        input logic [2:0] u, input exp_t e);
    bit acc;
    acc = 1'b0;
    set_in(s, c, c1, c2, u, e);
    in_valid = 1'b1;
    for (int k = 0; k < 40 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL push_timeout: got in_ready=0 expected accept within 40 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic push_rand(input logic [2:0] u);
    logic s, c, c1, c2;
    s = 1'($urandom); c = 1'($urandom); c1 = 1'($urandom); c2 = 1'($urandom);
    push_s(s, c, c1, c2, u, ref_res(s, c, c1, c2, u));
  endtask

  // Idle cycles with junk on the data lines; nothing must be accepted.
  task automatic idle(input int n);
    in_valid = 1'b0;
    set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), '0);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vec_t tv[8];
    tv[0] = mkv(1, 1, 0, 1, 3'b000, 5, 5, 0, 0);
    tv[1] = mkv(0, 1, 1, 0, 3'b101, 4, 8, 4, 0);
    tv[2] = mkv(1, 1, 1, 1, 3'b111, 7, 13, 6, 1);
    tv[3] = mkv(0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    tv[4] = mkv(1, 0, 0, 0, 3'b010, 1, 3, 2, 0);
    tv[5] = mkv(0, 1, 1, 1, 3'b011, 6, 10, 4, 1);
    tv[6] = mkv(1, 0, 1, 0, 3'b100, 3, 5, 2, 0);
    tv[7] = mkv(0, 0, 0, 1, 3'b110, 2, 6, 4, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(2);

    // Table vectors, streaming with out_ready high (push and pop together)
    out_ready = 1'b1;
    foreach (tv[i]) push_s(tv[i].s, tv[i].c, tv[i].c1, tv[i].c2, tv[i].u, tv[i].e);
    idle(2);

    // Clear counters, then fill the FIFO with out_ready low
    clr_stats = 1'b1;
    idle(1);
    clr_stats = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_rand(3'(i));
    chk("full_in_ready", in_ready, 0);
    set_in(1, 0, 1, 1, 3'b001, ref_res(1, 0, 1, 1, 3'b001));
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("held_in_ready", in_ready, 0);
    out_ready = 1'b1;
    push_s(1, 0, 1, 1, 3'b001, ref_res(1, 0, 1, 1, 3'b001));
    idle(6);
    chk("drained_valid", out_valid, 0);

    // clr_stats beats a same-cycle push; the sample still reaches the output
    clr_stats = 1'b1;
    push_s(0, 1, 0, 0, 3'b010, ref_res(0, 1, 0, 0, 3'b010));
    clr_stats = 1'b0;
    chk("clr_sample_cnt", sample_cnt, 0);
    chk("clr_err_mag", err_mag_acc, 0);
    chk("clr_push_delta", delta, 2);
    idle(2);

    // Saturation of err_mag_acc at 15
    for (int i = 0; i < 4; i++) push_rand(3'b111);
    idle(1);
    chk("sat_err_mag", err_mag_acc, CMAX);

    // Mixed stalls and bursts
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2 == 0);
      push_rand(3'($urandom));
      if (i % 4 == 3) begin
        out_ready = 1'b1;
        idle(3);
      end
    end
    idle(3);

    // Asynchronous reset mid-stream discards buffered samples
    out_ready = 1'b0;
    push_rand(3'b011);
    push_rand(3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_sample_cnt", sample_cnt, 0);
    chk("arst_err_evt", err_evt_cnt, 0);
    chk("arst_err_mag", err_mag_acc, 0);
    chk("arst_outputs", {inconsistent, delta, exact_cnt, apx_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
